// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_WORD_WIDTH = 16;
    localparam int FETCH_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_WORD_WIDTH-1:0] pc;
        logic [FETCH_WORD_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush overrides push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  entry,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = entry;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: follows brancher PC loads, reads memory one word at a
// time and hands {pc, instr} pairs to the decoder through a prefetch queue.
//
//   state | meaning
//   IDLE  | no valid fetch pointer yet
//   REQ   | memory read outstanding at tx_mem_addr
//   FULL  | pointer valid, queue full, waiting for a pop or a load
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD_WIDTH = FETCH_WORD_WIDTH,
    parameter int DEPTH      = FETCH_DEPTH
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  rx_pc_load,
    input  logic [WORD_WIDTH-1:0] rx_program_counter,
    output logic                  tx_mem_req,
    output logic [WORD_WIDTH-1:0] tx_mem_addr,
    input  logic                  rx_mem_ack,
    input  logic [WORD_WIDTH-1:0] rx_mem_data,
    output logic                  tx_instr_valid,
    output logic [WORD_WIDTH-1:0] tx_instr,
    output logic [WORD_WIDTH-1:0] tx_instr_pc,
    input  logic                  rx_instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [WORD_WIDTH-1:0] ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic                  ptr_vld_q, ptr_vld_d;
    logic                  discard_q, discard_d;

    logic                  ack, push, pop;
    logic [CW-1:0]         count, occ_next;
    fetch_entry_t          entry, head;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .pop     (pop),
        .flush   (rx_pc_load),
        .entry   (entry),
        .head    (head),
        .count   (count)
    );

    always_comb begin
        ack      = (state_q == REQ) && rx_mem_ack;
        pop      = (count != '0) && rx_instr_ready;
        push     = ack && !discard_q && !rx_pc_load;
        entry    = '{pc: ptr_q, instr: rx_mem_data};
        occ_next = rx_pc_load ? '0 : (count + CW'(push) - CW'(pop));

        ptr_d     = ptr_q;
        ptr_vld_d = ptr_vld_q | rx_pc_load;
        if (rx_pc_load) begin
            ptr_d = rx_program_counter;
        end else if (push) begin
            ptr_d = ptr_q + WORD_WIDTH'(1);
        end

        // A load while a read is in flight lets the read finish at its old
        // address but marks its data for dropping.
        discard_d = discard_q;
        if (ack) begin
            discard_d = 1'b0;
        end else if (rx_pc_load && (state_q == REQ)) begin
            discard_d = 1'b1;
        end

        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q == REQ) && !ack) begin
            state_d = REQ;
        end else if (!ptr_vld_d) begin
            state_d = IDLE;
        end else if (occ_next < CW'(DEPTH)) begin
            state_d = REQ;
            addr_d  = ptr_d;
        end else begin
            state_d = FULL;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            ptr_vld_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            ptr_vld_q <= ptr_vld_d;
            discard_q <= discard_d;
        end
    end

    assign tx_mem_req     = (state_q == REQ);
    assign tx_mem_addr    = addr_q;
    assign tx_instr_valid = (count != '0);
    assign tx_instr       = head.instr;
    assign tx_instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stream vector table plus backpressure,
// redirect, load-on-ack and async-reset sequences against a memory model.
module tb_fetch_unit;

    logic        aclk;
    logic        aresetn;
    logic        rx_pc_load;
    logic [15:0] rx_program_counter;
    logic        tx_mem_req;
    logic [15:0] tx_mem_addr;
    logic        rx_mem_ack;
    logic [15:0] rx_mem_data;
    logic        tx_instr_valid;
    logic [15:0] tx_instr;
    logic [15:0] tx_instr_pc;
    logic        rx_instr_ready;

    int          mem_lat;
    int          wait_cnt;
    int          ack_count;
    int          ack_base;
    int          n_vec;
    int          n_fail;
    logic        r_s, a_s;
    logic [15:0] mon_e;
    logic [15:0] got_addr;
    logic [15:0] exp_q [$];

    typedef struct {
        logic [15:0] load_pc;
        int          n_out;
        logic [15:0] exp_instr;
    } vec_t;
    vec_t vecs [4];

    fetch_unit dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .rx_pc_load         (rx_pc_load),
        .rx_program_counter (rx_program_counter),
        .tx_mem_req         (tx_mem_req),
        .tx_mem_addr        (tx_mem_addr),
        .rx_mem_ack         (rx_mem_ack),
        .rx_mem_data        (rx_mem_data),
        .tx_instr_valid     (tx_instr_valid),
        .tx_instr           (tx_instr),
        .tx_instr_pc        (tx_instr_pc),
        .rx_instr_ready     (rx_instr_ready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Memory: acks once a request has waited mem_lat cycles; data = addr ^ A5A5.
    assign rx_mem_ack  = tx_mem_req && (wait_cnt >= mem_lat);
    assign rx_mem_data = tx_mem_addr ^ 16'hA5A5;

    initial begin
        wait_cnt  = 0;
        ack_count = 0;
        forever begin
            @(negedge aclk);
            r_s = tx_mem_req;
            a_s = rx_mem_ack;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                wait_cnt = 0;
            end else if (r_s && a_s) begin
                wait_cnt = 0;
                ack_count++;
            end else if (r_s) begin
                wait_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard: every accepted head must match the oldest expected pc.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn && tx_instr_valid && rx_instr_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("stream_pc", tx_instr_pc, mon_e);
                check("stream_instr", tx_instr, mon_e ^ 16'hA5A5);
            end
        end
    end

    task automatic do_reset();
        aresetn    = 1'b0;
        rx_pc_load = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic drive_load(input logic [15:0] pc);
        @(posedge aclk);
        #1;
        rx_pc_load         = 1'b1;
        rx_program_counter = pc;
    endtask

    task automatic end_load();
        @(posedge aclk);
        #1;
        rx_pc_load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] pc);
        drive_load(pc);
        end_load();
    endtask

    task automatic push_exp(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(i));
    endtask

    task automatic wait_pending(input logic [15:0] addr, input bit pre_ack, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (tx_mem_req && tx_mem_addr == addr && !rx_mem_ack &&
                (!pre_ack || wait_cnt == mem_lat - 1)) found = 1'b1;
        end
        if (!found) timeout_fail(name);
    endtask

    task automatic wait_ack(output logic [15:0] addr, input string name);
        bit found;
        found = 1'b0;
        addr  = 'x;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (tx_mem_req && rx_mem_ack) begin
                found = 1'b1;
                addr  = tx_mem_addr;
            end
        end
        if (!found) timeout_fail(name);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0100, 6, 16'hA4A5};
        vecs[1] = '{16'hFFFE, 4, 16'h5A5B};
        vecs[2] = '{16'h1234, 5, 16'hB791};
        vecs[3] = '{16'h5A5A, 3, 16'hFFFF};

        n_vec              = 0;
        n_fail             = 0;
        aresetn            = 1'b1;
        rx_pc_load         = 1'b0;
        rx_program_counter = '0;
        rx_instr_ready     = 1'b0;
        mem_lat            = 0;

        #1 aresetn = 1'b0;
        #1;
        check("rst_req", 16'(tx_mem_req), 16'h0);
        check("rst_addr", tx_mem_addr, 16'h0000);
        check("rst_valid", 16'(tx_instr_valid), 16'h0);
        check("rst_instr", tx_instr, 16'h0000);
        check("rst_pc", tx_instr_pc, 16'h0000);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("idle_no_req", 16'(tx_mem_req), 16'h0);

        // Backpressure: queue fills to four entries, then request stops.
        ack_base = ack_count;
        do_load(16'h0100);
        repeat (8) @(negedge aclk);
        check("bp_req_full", 16'(tx_mem_req), 16'h0);
        check("bp_valid", 16'(tx_instr_valid), 16'h1);
        check("bp_head_pc", tx_instr_pc, 16'h0100);
        check("bp_head_instr", tx_instr, 16'hA4A5);
        check("bp_acks", 16'(ack_count - ack_base), 16'd4);
        push_exp(16'h0100, 4);
        @(posedge aclk);
        #1 rx_instr_ready = 1'b1;
        wait_ack(got_addr, "bp_next_req");
        check("bp_next_addr", got_addr, 16'h0104);
        wait_drain("bp_drain");

        // Stream table: zero-wait memory, ready high, first valid at cycle 2.
        for (int v = 0; v < 4; v++) begin
            drive_load(vecs[v].load_pc);
            end_load();
            push_exp(vecs[v].load_pc, vecs[v].n_out);
            @(negedge aclk);
            check("vec_c1_valid", 16'(tx_instr_valid), 16'h0);
            check("vec_c1_req", 16'(tx_mem_req), 16'h1);
            check("vec_c1_addr", tx_mem_addr, vecs[v].load_pc);
            @(negedge aclk);
            check("vec_c2_valid", 16'(tx_instr_valid), 16'h1);
            check("vec_c2_pc", tx_instr_pc, vecs[v].load_pc);
            check("vec_c2_instr", tx_instr, vecs[v].exp_instr);
            wait_drain("vec_drain");
        end

        // Redirect while the 0x0105 read is still waiting.
        do_reset();
        mem_lat = 3;
        do_load(16'h0100);
        push_exp(16'h0100, 5);
        wait_pending(16'h0105, 1'b0, "redir_pending");
        drive_load(16'h2000);
        end_load();
        push_exp(16'h2000, 3);
        @(negedge aclk);
        check("redir_valid", 16'(tx_instr_valid), 16'h0);
        check("redir_req_held", 16'(tx_mem_req), 16'h1);
        check("redir_addr_held", tx_mem_addr, 16'h0105);
        wait_ack(got_addr, "redir_old_ack");
        check("redir_old_addr", got_addr, 16'h0105);
        wait_ack(got_addr, "redir_new_ack");
        check("redir_new_addr", got_addr, 16'h2000);
        wait_drain("redir_drain");

        // Load in the same cycle as the 0x0107 ack.
        do_reset();
        mem_lat = 3;
        do_load(16'h0100);
        push_exp(16'h0100, 7);
        wait_pending(16'h0107, 1'b1, "coinc_pending");
        drive_load(16'h3000);
        @(negedge aclk);
        check("coinc_ack", 16'(rx_mem_ack), 16'h1);
        check("coinc_ack_addr", tx_mem_addr, 16'h0107);
        end_load();
        push_exp(16'h3000, 3);
        @(negedge aclk);
        check("coinc_next_req", 16'(tx_mem_req), 16'h1);
        check("coinc_next_addr", tx_mem_addr, 16'h3000);
        check("coinc_valid", 16'(tx_instr_valid), 16'h0);
        wait_drain("coinc_drain");

        // Async reset while a request is outstanding.
        do_reset();
        mem_lat = 3;
        do_load(16'h4000);
        wait_pending(16'h4000, 1'b0, "arst_pending");
        #3 aresetn = 1'b0;
        #1;
        exp_q.delete();
        check("arst_req", 16'(tx_mem_req), 16'h0);
        check("arst_addr", tx_mem_addr, 16'h0000);
        check("arst_valid", 16'(tx_instr_valid), 16'h0);
        check("arst_instr", tx_instr, 16'h0000);
        check("arst_pc", tx_instr_pc, 16'h0000);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("arst_idle_req", 16'(tx_mem_req), 16'h0);
        end
        check("arst_idle_valid", 16'(tx_instr_valid), 16'h0);
        do_load(16'h5000);
        @(negedge aclk);
        check("arst_reload_req", 16'(tx_mem_req), 16'h1);
        check("arst_reload_addr", tx_mem_addr, 16'h5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
